// File: rtl/cw_tone_analyzer_if.sv
// Sample-in / result-out bundle for the CW tone analyzer.
// The slave view is the analyzer; the master view is the sample source and result consumer.
interface cw_tone_analyzer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 24
);
  logic                           io_in_valid;
  logic signed [DATA_WIDTH-1:0]   io_in_value;
  logic                           io_out_valid;
  logic                           io_out_ready;
  logic        [PERIOD_WIDTH-1:0] io_out_period;
  logic signed [DATA_WIDTH-1:0]   io_out_peak;
  logic signed [DATA_WIDTH-1:0]   io_out_trough;
  logic                           io_locked;
  logic                           io_overrun;

  modport master (
    output io_in_valid, io_in_value, io_out_ready,
    input  io_out_valid, io_out_period, io_out_peak, io_out_trough,
    input  io_locked, io_overrun
  );

  modport slave (
    input  io_in_valid, io_in_value, io_out_ready,
    output io_out_valid, io_out_period, io_out_peak, io_out_trough,
    output io_locked, io_overrun
  );
endinterface

// File: rtl/cw_tone_analyzer.sv
// Measures period, peak and trough of a signed tone between rising crossings with hysteresis,
// rejects short glitch periods, and hands each result out through a one-entry valid/ready register.
module cw_tone_analyzer #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          PERIOD_WIDTH = 24,
  parameter int unsigned HYST         = 0,
  parameter int unsigned MIN_PERIOD   = 4
) (
  input  logic              clock,
  input  logic              reset,
  cw_tone_analyzer_if.slave tone
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ARMED0  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam logic [PERIOD_WIDTH-1:0]      COUNT_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0]      COUNT_ONE = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0]      MIN_COUNT = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic signed [DATA_WIDTH-1:0] HYST_POS  = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0] HYST_NEG  = -HYST_POS;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] smin(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  logic [1:0]                     state_r,  state_nxt_s;
  logic [PERIOD_WIDTH-1:0]        count_r,  count_nxt_s, count_inc_s;
  logic signed [DATA_WIDTH-1:0]   max_r,    max_nxt_s;
  logic signed [DATA_WIDTH-1:0]   min_r,    min_nxt_s;
  logic                           armed_r,  armed_nxt_s;
  logic signed [DATA_WIDTH-1:0]   sample_s;
  logic                           is_low_s, is_cross_s;
  logic                           emit_s,   unlock_s, load_s, drop_s;

  logic                           out_valid_r;
  logic [PERIOD_WIDTH-1:0]        out_period_r;
  logic signed [DATA_WIDTH-1:0]   out_peak_r;
  logic signed [DATA_WIDTH-1:0]   out_trough_r;
  logic                           locked_r;
  logic                           overrun_r;

  assign sample_s   = tone.io_in_value;
  assign is_low_s   = (sample_s < HYST_NEG);
  assign is_cross_s = (sample_s >= HYST_POS);

  // Crossing detection and per-period accumulation; only valid samples advance state.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    max_nxt_s   = max_r;
    min_nxt_s   = min_r;
    armed_nxt_s = armed_r;
    emit_s      = 1'b0;
    unlock_s    = 1'b0;
    count_inc_s = (count_r == COUNT_MAX) ? COUNT_MAX : (count_r + COUNT_ONE);
    if (tone.io_in_valid) begin
      case (state_r)
        SEARCH: begin
          if (is_low_s) begin
            state_nxt_s = ARMED0;
          end else begin
            state_nxt_s = SEARCH;
          end
        end
        ARMED0: begin
          if (is_cross_s) begin
            state_nxt_s = MEASURE;
            count_nxt_s = COUNT_ONE;
            max_nxt_s   = sample_s;
            min_nxt_s   = sample_s;
            armed_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ARMED0;
          end
        end
        MEASURE: begin
          if (is_cross_s && armed_r) begin
            // count_r still excludes the crossing sample, so it is the completed period
            if (count_r >= MIN_COUNT) begin
              emit_s = 1'b1;
            end else begin
              unlock_s = 1'b1;
            end
            state_nxt_s = MEASURE;
            count_nxt_s = COUNT_ONE;
            max_nxt_s   = sample_s;
            min_nxt_s   = sample_s;
            armed_nxt_s = 1'b0;
          end else begin
            count_nxt_s = count_inc_s;
            max_nxt_s   = smax(max_r, sample_s);
            min_nxt_s   = smin(min_r, sample_s);
            armed_nxt_s = armed_r | is_low_s;
            if (count_inc_s == COUNT_MAX) begin
              state_nxt_s = SEARCH;
              unlock_s    = 1'b1;
            end else begin
              state_nxt_s = MEASURE;
            end
          end
        end
        default: begin
          state_nxt_s = SEARCH;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Result register acceptance: load when empty or draining this cycle, otherwise drop.
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    if (emit_s) begin
      if (!out_valid_r || tone.io_out_ready) begin
        load_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Measurement state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= SEARCH;
      count_r <= {PERIOD_WIDTH{1'b0}};
      max_r   <= {DATA_WIDTH{1'b0}};
      min_r   <= {DATA_WIDTH{1'b0}};
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      max_r   <= max_nxt_s;
      min_r   <= min_nxt_s;
      armed_r <= armed_nxt_s;
    end
  end

  // Result register, lock indicator and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_period_r <= {PERIOD_WIDTH{1'b0}};
      out_peak_r   <= {DATA_WIDTH{1'b0}};
      out_trough_r <= {DATA_WIDTH{1'b0}};
      locked_r     <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (load_s) begin
        out_valid_r  <= 1'b1;
        out_period_r <= count_r;
        out_peak_r   <= max_r;
        out_trough_r <= min_r;
      end else if (out_valid_r && tone.io_out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
      if (emit_s) begin
        locked_r <= 1'b1;
      end else if (unlock_s) begin
        locked_r <= 1'b0;
      end
    end
  end

  assign tone.io_out_valid  = out_valid_r;
  assign tone.io_out_period = out_period_r;
  assign tone.io_out_peak   = out_peak_r;
  assign tone.io_out_trough = out_trough_r;
  assign tone.io_locked     = locked_r;
  assign tone.io_overrun    = overrun_r;

endmodule

// File: tb/tb_cw_tone_analyzer.sv
// Scoreboard bench for cw_tone_analyzer: directed waveforms plus random segments, checked against
// a sample-history reference model; a negedge monitor pops expected results as the DUT presents them.
module tb_cw_tone_analyzer;

  localparam int DW      = 32;
  localparam int PW      = 8;
  localparam int HYST    = 0;
  localparam int MIN_P   = 4;
  localparam int SAT_LEN = (1 << PW) - 1;

  typedef struct {
    int                   period;
    logic signed [DW-1:0] peak;
    logic signed [DW-1:0] trough;
  } res_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;

  always #5 clock = ~clock;

  cw_tone_analyzer_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) bus ();

  cw_tone_analyzer #(
    .DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .HYST(HYST), .MIN_PERIOD(MIN_P)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tone (bus)
  );

  // reference model state
  res_t                 exp_q[$];
  logic signed [DW-1:0] hist[$];
  bit                   started   = 1'b0;
  bit                   seen_low  = 1'b0;
  bit                   m_full    = 1'b0;
  bit                   m_locked  = 1'b0;
  bit                   m_overrun = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the period is the list of samples since the last accepted rising crossing.
  initial begin
    logic signed [DW-1:0] s;
    bit   emit, drain, any_low;
    res_t r;
    forever begin
      @(posedge clock);
      if (reset) begin
        started = 0; seen_low = 0; m_full = 0; m_locked = 0; m_overrun = 0;
        hist.delete();
        exp_q.delete();
      end else begin
        emit = 0;
        if (bus.io_in_valid) begin
          s = bus.io_in_value;
          if (!started) begin
            if (seen_low && s >= HYST) begin
              started = 1;
              hist.delete();
              hist.push_back(s);
            end else if (s < -HYST) begin
              seen_low = 1;
            end
          end else begin
            any_low = 0;
            foreach (hist[i]) if (hist[i] < -HYST) any_low = 1;
            if (s >= HYST && any_low) begin
              r.period = hist.size();
              r.peak   = hist[0];
              r.trough = hist[0];
              foreach (hist[i]) begin
                if (hist[i] > r.peak)   r.peak   = hist[i];
                if (hist[i] < r.trough) r.trough = hist[i];
              end
              if (r.period >= MIN_P) emit = 1;
              else m_locked = 0;
              hist.delete();
              hist.push_back(s);
            end else begin
              hist.push_back(s);
              if (hist.size() == SAT_LEN) begin
                started = 0; seen_low = 0; m_locked = 0;
                hist.delete();
              end
            end
          end
        end
        drain = m_full && bus.io_out_ready;
        if (emit) begin
          m_locked = 1;
          if (!m_full || drain) begin
            m_full = 1;
            exp_q.push_back(r);
          end else begin
            m_overrun = 1;
          end
        end else if (drain) begin
          m_full = 0;
        end
      end
    end
  end

  // Monitor: compare flags every cycle, compare and retire the head result when presented.
  initial begin
    res_t h;
    forever begin
      @(negedge clock);
      chk("out_valid", bus.io_out_valid, m_full);
      chk("locked", bus.io_locked, m_locked);
      chk("overrun", bus.io_overrun, m_overrun);
      if (bus.io_out_valid && m_full) begin
        if (exp_q.size() == 0) begin
          chk("result_expected", 1, 0);
        end else begin
          h = exp_q[0];
          chk("period", bus.io_out_period, h.period);
          chk("peak", bus.io_out_peak, h.peak);
          chk("trough", bus.io_out_trough, h.trough);
          if (bus.io_out_ready) begin
            void'(exp_q.pop_front());
            accepted++;
          end
        end
      end
    end
  end

  task automatic step(input bit v, input int val, input bit rdy);
    bus.io_in_valid  = v;
    bus.io_in_value  = val;
    bus.io_out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic square(input int periods, input int amp, input int half, input bit toggle, input bit rdy);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < 2 * half; i++) begin
        step(1'b1, (i < half) ? -amp : amp, rdy);
        if (toggle) step(1'b0, int'($urandom), rdy);
      end
    end
  endtask

  initial begin
    int amp, half, v, rdyp;
    reset = 1'b1;
    bus.io_in_valid  = 1'b0;
    bus.io_in_value  = '0;
    bus.io_out_ready = 1'b1;
    repeat (3) step(1'b0, 0, 1'b1);
    chk("rst_period", bus.io_out_period, 0);
    chk("rst_peak", bus.io_out_peak, 0);
    chk("rst_trough", bus.io_out_trough, 0);
    reset = 1'b0;

    square(6, 100, 4, 1'b0, 1'b1);
    square(4, 100, 4, 1'b1, 1'b1);

    // backpressure through several crossings, then a one-cycle drain
    square(4, 100, 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1);
    repeat (3) step(1'b0, 0, 1'b0);
    square(2, 100, 4, 1'b0, 1'b1);

    // glitch pattern after lock
    for (int i = 0; i < 40; i++) begin
      step(1'b1, -5, 1'b1);
      step(1'b1, 5, 1'b1);
    end

    // saturation then relock
    square(3, 100, 4, 1'b0, 1'b1);
    repeat (300) step(1'b1, 50, 1'b1);
    square(4, 100, 4, 1'b0, 1'b1);

    // reset mid-measurement with a result held
    square(3, 100, 4, 1'b0, 1'b0);
    step(1'b1, -100, 1'b0);
    step(1'b1, -100, 1'b0);
    reset = 1'b1;
    step(1'b1, 100, 1'b0);
    reset = 1'b0;
    chk("rst2_valid", bus.io_out_valid, 0);
    chk("rst2_period", bus.io_out_period, 0);
    chk("rst2_peak", bus.io_out_peak, 0);
    chk("rst2_trough", bus.io_out_trough, 0);
    chk("rst2_locked", bus.io_locked, 0);
    chk("rst2_overrun", bus.io_overrun, 0);
    square(4, 100, 4, 1'b0, 1'b1);

    // random segments: amplitudes, half-periods, idle gaps, backpressure and noise
    for (int seg = 0; seg < 150; seg++) begin
      amp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 32'h7fff_ffff)) : int'($urandom_range(1, 1000));
      half = $urandom_range(1, 8);
      v    = $urandom_range(0, 3);
      rdyp = $urandom_range(0, 3);
      for (int i = 0; i < 2 * half; i++) begin
        if ($urandom_range(0, 15) == 0)
          step(1'b1, int'($urandom), ($urandom_range(0, 3) < rdyp) || rdyp == 3);
        else
          step((v == 0) ? $urandom_range(0, 1) == 1 : 1'b1, (i < half) ? -amp : amp,
               ($urandom_range(0, 3) < rdyp) || rdyp == 3);
      end
    end
    repeat (4) step(1'b0, 0, 1'b1);

    chk("results_accepted_nonzero", (accepted > 20) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cw_tone_analyzer.md
Name: cw_tone_analyzer

Overview:
- Receive-side counterpart of the CW DDS core. It consumes a signed sample stream, such as the DDS core's 32-bit output, and detects rising zero crossings with hysteresis.
- Per waveform period it measures the length in samples plus the peak and trough values. Each result goes out through a one-entry valid/ready result register.
- Used for closed-loop self-check of the DDS tuning word and amplitude in simulation and on hardware.

Parameters:
- DATA_WIDTH, 32, sample width; samples and peak/trough are two's-complement signed.
- PERIOD_WIDTH, 24, period counter width; the counter saturates at 2^PERIOD_WIDTH-1.
- HYST, 0, hysteresis threshold, unsigned, must be < 2^(DATA_WIDTH-1).
- MIN_PERIOD, 4, shortest period accepted; shorter periods are glitches.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- io_in_valid  in  1  sample strobe; one sample per cycle when high.
- io_in_value  in  DATA_WIDTH  signed sample.
- io_out_valid  out  1  result register holds an unconsumed result.
- io_out_ready  in  1  consumer accepts the result when valid&&ready.
- io_out_period  out  PERIOD_WIDTH  period length in accepted samples.
- io_out_peak  out  DATA_WIDTH  signed max sample over the period.
- io_out_trough  out  DATA_WIDTH  signed min sample over the period.
- io_locked  out  1  high after the first emitted result, until loss of lock.
- io_overrun  out  1  sticky; a result was dropped because the register was full.

Behaviour:
- Clock and reset:
  - One clock, named clock.
  - reset is synchronous and active-high.
- Reset values:
  - io_out_valid=0, io_out_period=0, io_out_peak=0, io_out_trough=0.
  - io_locked=0, io_overrun=0.
  - State is SEARCH; the count, max and min registers are 0.
  - Reset asserted mid-measurement or with a result held discards everything; all outputs read reset values the cycle after reset is sampled.
- Sample handling:
  - Only cycles with io_in_valid=1 advance anything. Idle cycles hold all state, and the period counts samples, not clocks.
  - All comparisons are signed.
  - "low" means sample < -HYST; "cross" means sample >= HYST.
- States:
  - SEARCH:
    - A low sample moves to ARMED0.
  - ARMED0:
    - A cross sample moves to MEASURE with count=1 and max=min=that sample.
  - MEASURE:
    - On each sample: count+=1 (saturating), and max/min are updated.
    - A low sample sets the internal flag armed=1.
    - A cross sample with armed=1 is a crossing. The completed period P=count, taken before that sample is added. Then:
      - if P>=MIN_PERIOD, emit (P, max, min);
      - otherwise discard the period as a glitch and clear io_locked.
      - In both cases restart: count=1, max=min=crossing sample, armed=0, stay in MEASURE.
    - Saturation: when count reaches 2^PERIOD_WIDTH-1 without a crossing, go to SEARCH and clear io_locked. Nothing is emitted.
- Emit:
  - Output fields update on the clock edge that samples the crossing, so they are visible 1 cycle after the crossing sample is presented.
  - io_locked is set on the same edge.
  - The register loads when it is empty or being drained the same cycle (io_out_valid&&io_out_ready); in the drain case io_out_valid stays 1.
  - If it is full and not draining, the new result is dropped, the held result is unchanged, and io_overrun is set.
- io_overrun clears only on reset.
- Output stability: while io_out_valid=1 and io_out_ready=0, all io_out_* fields are held stable.
- Throughput: one result per cycle maximum; latency is fixed at 1 cycle with no pipelining beyond that.

Test Plan:
- Square-wave pattern [-100×4, +100×4] repeated, io_in_valid=1, io_out_ready=1, defaults:
  - first result is emitted 1 cycle after the second rising crossing;
  - period=8, peak=100, trough=-100, io_locked=1;
  - then one result every 8 cycles.
- Same pattern with io_in_valid toggling 1,0,1,0:
  - period still 8;
  - results every 16 cycles;
  - outputs unchanged across idle cycles.
- Backpressure: io_out_ready=0 through three crossings:
  - first result is held bit-stable;
  - io_overrun=1 after the second crossing;
  - raising ready for 1 cycle accepts the first result, then io_out_valid=0 until the next crossing.
- Glitch, HYST=0, MIN_PERIOD=4: pattern [-5, +5] repeated:
  - no io_out_valid ever;
  - io_locked stays 0 (or drops to 0 if previously locked by the Test 1 pattern).
- Saturation, PERIOD_WIDTH=8: lock with the Test 1 pattern, then constant +50 for 300 samples:
  - io_locked falls when the count reaches 255;
  - no result is emitted;
  - re-applying the Test 1 pattern relocks with period=8.
- Reset mid-MEASURE with a result held:
  - the cycle after reset all outputs are 0 and io_overrun=0;
  - with the Test 1 pattern afterwards, the first result appears only after two fresh crossings.
